// File: rtl/pe_gene_pkg.sv
// Shared definitions for the gene feeder: default widths, attribute field offsets,
// the max-key sentinel gene and the feeder state encoding.
package pe_gene_pkg;

    localparam int GENE_SZ_DEF = 64;
    localparam int ATTR_SZ_DEF = 8;
    localparam int ADDR_SZ_DEF = 10;
    localparam int CNT_SZ_DEF  = 10;

    localparam int SRC1_LSB = 5 * ATTR_SZ_DEF;
    localparam int SRC2_LSB = 4 * ATTR_SZ_DEF;

    // src1 and src2 all ones, everything else zero: larger than any real key
    localparam logic [GENE_SZ_DEF-1:0] SENTINEL_GENE =
        {{(GENE_SZ_DEF - 6 * ATTR_SZ_DEF){1'b0}},
         {(2 * ATTR_SZ_DEF){1'b1}},
         {SRC2_LSB{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_SENTINEL = 2'd2,
        ST_DONE     = 2'd3
    } feed_state_e;

endpackage

// File: rtl/pe_gene_feeder_fifo.sv
// Two-entry skid FIFO that absorbs the one-cycle memory read latency while the
// gene queue is stalled. A push against a full FIFO without a pop is dropped.
module gene_skid_fifo #(
    parameter int WORD_SZ = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [WORD_SZ-1:0] i_din,
    output logic [WORD_SZ-1:0] o_dout,
    output logic               o_empty,
    output logic               o_full,
    output logic [1:0]         o_count
);

    logic [WORD_SZ-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == 2'd0);
    assign o_full    = (r_count == 2'd2);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_do_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= i_din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_gene_feeder.sv
// Producer side of the per-PE gene queue: streams one genome from gene memory
// into the queue, then a max-key sentinel. Optional key-order checker: GENE_FEED_ORDER_CHK_EN.
module pe_gene_feeder
    import pe_gene_pkg::*;
#(
    parameter int GENE_SZ = GENE_SZ_DEF,
    parameter int ATTR_SZ = ATTR_SZ_DEF,
    parameter int ADDR_SZ = ADDR_SZ_DEF,
    parameter int CNT_SZ  = CNT_SZ_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [ADDR_SZ-1:0] i_base_addr,
    input  logic [CNT_SZ-1:0]  i_gene_cnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_mem_rd_en,
    output logic [ADDR_SZ-1:0] o_mem_addr,
    input  logic [GENE_SZ-1:0] i_mem_rd_data,
    output logic               o_q_wr,
    output logic [GENE_SZ-1:0] o_q_data,
    input  logic               i_q_full
`ifdef GENE_FEED_ORDER_CHK_EN
    ,
    output logic               o_order_err
`endif
);

    localparam logic [GENE_SZ-1:0] L_SENTINEL =
        {{(GENE_SZ - 2 * ATTR_SZ){1'b0}}, {(2 * ATTR_SZ){1'b1}}} << (4 * ATTR_SZ);

    feed_state_e        r_state;
    feed_state_e        w_state_next;
    logic [ADDR_SZ-1:0] r_rd_addr;
    logic [CNT_SZ-1:0]  r_rd_left;
    logic [CNT_SZ-1:0]  r_wr_left;
    logic               r_inflight;

    logic               w_start_ok;
    logic               w_pop;
    logic               w_rd_issue;
    logic [GENE_SZ-1:0] w_fifo_dout;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [1:0]         w_fifo_count;

    assign w_start_ok = (r_state == ST_IDLE) && i_start;
    assign w_pop      = (r_state == ST_FETCH) && !w_fifo_empty && !i_q_full;

    // Entries held or on their way must stay within the two FIFO slots
    assign w_rd_issue = (r_state == ST_FETCH) && (r_rd_left != '0) &&
                        (({1'b0, w_fifo_count} + {2'b00, r_inflight}) <
                         (3'd2 + {2'b00, w_pop}));

    gene_skid_fifo #(
        .WORD_SZ (GENE_SZ)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_din   (i_mem_rd_data),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_inflight && w_fifo_full && !w_pop))
        else $error("gene skid FIFO overflow");

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_gene_cnt == '0) ? ST_SENTINEL : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_pop && (r_wr_left == CNT_SZ'(1))) begin
                    w_state_next = ST_SENTINEL;
                end
            end
            ST_SENTINEL: begin
                if (!i_q_full) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_DONE);
        o_mem_rd_en = w_rd_issue;
        o_mem_addr  = r_rd_addr;
        o_q_wr      = 1'b0;
        o_q_data    = '0;
        case (r_state)
            ST_FETCH: begin
                o_q_wr   = !w_fifo_empty && !i_q_full;
                o_q_data = w_fifo_dout;
            end
            ST_SENTINEL: begin
                o_q_wr   = 1'b1;
                o_q_data = L_SENTINEL;
            end
            default: begin
                o_q_wr   = 1'b0;
                o_q_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr  <= '0;
            r_rd_left  <= '0;
            r_wr_left  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_start_ok) begin
                r_rd_addr <= i_base_addr;
                r_rd_left <= i_gene_cnt;
                r_wr_left <= i_gene_cnt;
            end else begin
                if (w_rd_issue) begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                    r_rd_left <= r_rd_left - 1'b1;
                end
                if (w_pop) begin
                    r_wr_left <= r_wr_left - 1'b1;
                end
            end
        end
    end

`ifdef GENE_FEED_ORDER_CHK_EN
    logic [2*ATTR_SZ-1:0] w_key;
    logic [2*ATTR_SZ-1:0] r_prev_key;
    logic                 r_have_prev;
    logic                 r_order_err;

    assign w_key       = w_fifo_dout[6*ATTR_SZ-1:4*ATTR_SZ];
    assign o_order_err = r_order_err;

    // Only FIFO-sourced writes are checked, so the sentinel never participates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_key  <= '0;
            r_have_prev <= 1'b0;
            r_order_err <= 1'b0;
        end else if (w_start_ok) begin
            r_have_prev <= 1'b0;
            r_order_err <= 1'b0;
        end else if (w_pop) begin
            if (r_have_prev && (w_key <= r_prev_key)) begin
                r_order_err <= 1'b1;
            end
            r_prev_key  <= w_key;
            r_have_prev <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_gene_feeder.sv
// Scoreboard bench for pe_gene_feeder: expected addresses and queue words are queued at
// each start and consumed by a negedge monitor as the DUT presents them.
module tb_pe_gene_feeder;
    import pe_gene_pkg::*;

    localparam int GENE_SZ = 64;
    localparam int ATTR_SZ = 8;
    localparam int ADDR_SZ = 10;
    localparam int CNT_SZ  = 10;
    localparam logic [63:0] SENT = 64'h0000_FFFF_0000_0000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_SZ-1:0] base_addr = '0;
    logic [CNT_SZ-1:0]  gene_cnt = '0;
    logic               busy, done, mem_rd_en, q_wr;
    logic [ADDR_SZ-1:0] mem_addr;
    logic [GENE_SZ-1:0] mem_rd_data = '0;
    logic [GENE_SZ-1:0] q_data;
    logic               q_full = 1'b0;
`ifdef GENE_FEED_ORDER_CHK_EN
    logic               order_err;
`endif

    pe_gene_feeder #(
        .GENE_SZ (GENE_SZ),
        .ATTR_SZ (ATTR_SZ),
        .ADDR_SZ (ADDR_SZ),
        .CNT_SZ  (CNT_SZ)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_base_addr   (base_addr),
        .i_gene_cnt    (gene_cnt),
        .o_busy        (busy),
        .o_done        (done),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_addr    (mem_addr),
        .i_mem_rd_data (mem_rd_data),
        .o_q_wr        (q_wr),
        .o_q_data      (q_data),
        .i_q_full      (q_full)
`ifdef GENE_FEED_ORDER_CHK_EN
        ,
        .o_order_err   (order_err)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [9:0]  exp_a [$];
    int n_rd, n_wr, n_gene_wr, first_rd_cyc, last_rd_cyc, first_wr_cyc, last_wr_cyc;
    int max_out, done_cyc, start_cyc;
    bit done_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=<nothing>", name, act);
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_gene_wr = 0; max_out = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
        done_cyc = -1; done_seen = 0;
    endtask

    // Monitor: one scoreboard pop per read strobe and per accepted queue write
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                if (n_rd == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                n_rd++;
                if (exp_a.size() == 0) chk_unexpected("rd_addr_extra", 64'(mem_addr));
                else chk("rd_addr", 64'(mem_addr), 64'(exp_a.pop_front()));
            end
            if (q_wr && !q_full) begin
                if (n_wr == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                n_wr++;
                if (q_data !== SENT) n_gene_wr++;
                if (exp_q.size() == 0) chk_unexpected("q_data_extra", q_data);
                else chk("q_data", q_data, exp_q.pop_front());
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            if (n_rd - n_gene_wr > max_out) max_out = n_rd - n_gene_wr;
        end
    end

    task automatic do_start(input logic [9:0] base, input logic [9:0] cnt, input bit expect_it);
        @(posedge clk); #1;
        if (expect_it) begin
            clear_stats();
            for (int i = 0; i < int'(cnt); i++) begin
                logic [9:0] a;
                a = base + 10'(i);
                exp_a.push_back(a);
                exp_q.push_back(mem[a]);
            end
            exp_q.push_back(SENT);
            start_cyc = cyc;
        end
        $display("START base=%03h cnt=%0d %s", base, cnt, expect_it ? "expected" : "while-busy");
        base_addr = base;
        gene_cnt  = cnt;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done_seen && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (!done_seen) begin
            chk_unexpected({name, "_done_timeout"}, 64'(t));
        end else begin
            chk({name, "_done_after_sentinel"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
            #1;
            chk({name, "_busy_low"}, 64'(busy), 64'd0);
            chk({name, "_sb_empty"}, 64'(exp_q.size() + exp_a.size()), 64'd0);
        end
        $display("DONE %s reads=%0d writes=%0d", name, n_rd, n_wr);
    endtask

    function automatic logic [63:0] mk(input logic [9:0] a, input logic [15:0] key);
        return {16'hBEEF, key, 22'h0, a};
    endfunction

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = mk(10'(a), {6'h0, 10'(a)});
        mem[10'h010] = mk(10'h010, 16'h0102);
        mem[10'h011] = mk(10'h011, 16'h0105);
        mem[10'h012] = mk(10'h012, 16'h0201);
        mem[10'h013] = mk(10'h013, 16'h0300);
        mem[10'h100] = mk(10'h100, 16'h0301);
        mem[10'h101] = mk(10'h101, 16'h0204);
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_q_wr", 64'(q_wr), 64'd0);
        chk("rst_q_data", q_data, 64'd0);
        rst_n = 1'b1;

        // Basic stream: 4 genes back to back
        do_start(10'h010, 10'd4, 1'b1);
        wait_done("basic");
        chk("basic_latency", 64'(first_wr_cyc - start_cyc), 64'd3);
        chk("basic_wr_span", 64'(last_wr_cyc - first_wr_cyc), 64'd4);
        chk("basic_n_wr", 64'(n_wr), 64'd5);
        chk("basic_rd_span", 64'(last_rd_cyc - first_rd_cyc), 64'd3);
        chk("basic_n_rd", 64'(n_rd), 64'd4);
`ifdef GENE_FEED_ORDER_CHK_EN
        chk("basic_order_err", 64'(order_err), 64'd0);
`endif

        // Backpressure: queue full for 3 cycles after the 2nd write
        do_start(10'h020, 10'd6, 1'b1);
        begin
            int t = 0;
            while (n_gene_wr < 2 && t < 100) begin @(posedge clk); t++; end
            if (n_gene_wr < 2) chk_unexpected("stall_wait_timeout", 64'(t));
        end
        #1 q_full = 1'b1;
        repeat (3) @(posedge clk);
        #1 q_full = 1'b0;
        wait_done("stall");
        chk("stall_n_rd", 64'(n_rd), 64'd6);
        chk("stall_n_gene", 64'(n_gene_wr), 64'd6);
        chk("stall_wr_span", 64'(last_wr_cyc - first_wr_cyc), 64'd9);
        chk("stall_max_outstanding_le2", 64'(max_out <= 2), 64'd1);

        // Empty genome: sentinel only
        do_start(10'h055, 10'd0, 1'b1);
        wait_done("empty");
        chk("empty_n_rd", 64'(n_rd), 64'd0);
        chk("empty_n_wr", 64'(n_wr), 64'd1);
        chk("empty_latency", 64'(first_wr_cyc - start_cyc), 64'd1);

        // Start while busy must be ignored
        do_start(10'h040, 10'd5, 1'b1);
        do_start(10'h200, 10'd3, 1'b0);
        wait_done("busy_start");
        chk("busy_start_n_rd", 64'(n_rd), 64'd5);

        // Address wrap at the top of memory
        do_start(10'h3FE, 10'd3, 1'b1);
        wait_done("wrap");
        chk("wrap_n_rd", 64'(n_rd), 64'd3);

        // Reset during the 3rd write
        do_start(10'h080, 10'd6, 1'b1);
        begin
            int t = 0;
            while (n_gene_wr < 2 && t < 100) begin @(posedge clk); t++; end
            if (n_gene_wr < 2) chk_unexpected("rst_wait_timeout", 64'(t));
        end
        #1;
        chk("midrst_pre_q_wr", 64'(q_wr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_q_wr", 64'(q_wr), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
        exp_q.delete();
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_start(10'h0C0, 10'd3, 1'b1);
        wait_done("after_rst");
        chk("after_rst_n_gene", 64'(n_gene_wr), 64'd3);
        chk("after_rst_latency", 64'(first_wr_cyc - start_cyc), 64'd3);

`ifdef GENE_FEED_ORDER_CHK_EN
        do_start(10'h100, 10'd2, 1'b1);
        wait_done("order");
        chk("order_err_set", 64'(order_err), 64'd1);
        do_start(10'h010, 10'd4, 1'b1);
        chk("order_err_cleared_by_start", 64'(order_err), 64'd0);
        wait_done("order_clean");
        chk("order_err_clean", 64'(order_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_gene_feeder.md
Name: pe_gene_feeder

Overview:
- Producer (write) side of the per-PE gene circular queue. The PE front end is the consumer of that queue.
- On a start command, fetches one genome (gene_cnt consecutive GENE_SZ words) from gene memory and pushes the words into the queue in address order.
- Honours queue backpressure, then terminates the stream with a max-key sentinel gene, so the front-end merge always drains the other stream.
- Sits between the NIC/gene memory and the PE front end. One instance per gene stream.

Parameters:
GENE_SZ, 64, gene word width
ATTR_SZ, 8, width of each gene attribute field
ADDR_SZ, 10, gene memory address width
CNT_SZ, 10, width of the gene count

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle command; sampled only in IDLE
base_addr  in  ADDR_SZ  first memory address of the genome
gene_cnt  in  CNT_SZ  number of genes, 0 allowed
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the sentinel is written
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_SZ  memory read address
mem_rd_data  in  GENE_SZ  read data, valid exactly 1 cycle after mem_rd_en
q_wr  out  1  queue write strobe
q_data  out  GENE_SZ  queue write data
q_full  in  1  queue full; a write is accepted only when q_full=0

Behaviour:
- Reset values (asynchronous): busy=0, done=0, mem_rd_en=0, mem_addr=0, q_wr=0, q_data=0. State=IDLE. Counters and skid FIFO are cleared.
- Reset mid-operation: the stream is aborted with no sentinel. q_wr drops to 0 immediately.
- States:
  - IDLE: on start, latch base_addr into rd_addr and gene_cnt into rd_left and wr_left. Go to FETCH, or to SENTINEL if gene_cnt=0.
  - FETCH: issue reads and drain the skid FIFO into the queue. When wr_left reaches 0, go to SENTINEL.
  - SENTINEL: hold q_wr=1 with the sentinel until q_full=0 in that cycle, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Read issue:
  - mem_rd_en=1 when rd_left>0 and (fifo_count + inflight − pop) < 2.
  - pop means a queue write is accepted this cycle.
  - inflight is 1 if a read was issued in the previous cycle.
  - Each read sends mem_addr=rd_addr, then rd_addr+1 and rd_left−1.
  - Addresses wrap modulo 2^ADDR_SZ.
- Returned mem_rd_data is pushed into a 2-entry skid FIFO. By construction the FIFO never overflows; overflow is an assertion error.
- Queue write:
  - q_wr = FIFO not empty and q_full=0.
  - q_data = FIFO head; q_wr and q_data are combinational from registers.
  - Each accepted write decrements wr_left.
- Throughput is 1 gene/cycle with q_full=0. Latency from start to the first q_wr is 3 cycles.
- Backpressure: no gene is lost or duplicated, order is strictly the address order, and reads stall while the FIFO is full.
- Sentinel gene: src1 field [6*ATTR_SZ-1:5*ATTR_SZ] and src2 field [5*ATTR_SZ-1:4*ATTR_SZ] are all ones; all other bits are 0.
- start asserted while busy is ignored. start together with reset low is ignored.
- busy=1 in FETCH, SENTINEL and DONE.

Optional Feature:
- Macro GENE_FEED_ORDER_CHK_EN.
- Defined:
  - Adds output order_err (1 bit), a sticky flag cleared by reset or an accepted start.
  - order_err is set when a written gene's key {src1,src2} is not strictly greater than the key of the previous gene in the same genome.
  - The sentinel is excluded from the check.
  - The data stream is unaffected.
- Undefined: the order_err port and all check logic are absent.

Decomposition:
- Package pe_gene_pkg:
  - field offsets SRC1_LSB=5*ATTR_SZ and SRC2_LSB=4*ATTR_SZ
  - the sentinel constant
  - the state encoding IDLE/FETCH/SENTINEL/DONE
- Sub-module gene_skid_fifo:
  - 2-entry synchronous FIFO, parameter WORD_SZ
  - ports push, pop, din, dout, empty, full, count
  - asynchronous active-low reset

Test Plan:
- base_addr=0x010, gene_cnt=4, q_full=0, mem holds keys 0x0102, 0x0105, 0x0201, 0x0300 → mem_addr 0x010..0x013 on consecutive cycles, then 5 consecutive q_wr (4 genes in order, then the sentinel with src fields 0xFF/0xFF), done one cycle later, busy low after done.
- gene_cnt=6 with q_full high for 3 cycles after the 2nd write → exactly 6 genes plus sentinel in order, no duplicates, mem_rd_en stalls, FIFO count never exceeds 2.
- gene_cnt=0 → a single q_wr carrying the sentinel, then done; mem_rd_en never asserted.
- start pulsed again while busy with base_addr=0x200 → ignored; addresses stay in the original range.
- rst low during the 3rd write → q_wr, busy and mem_rd_en are 0 in the same cycle; a new start after release streams correctly from its own base_addr.
- With GENE_FEED_ORDER_CHK_EN, keys 0x0301 then 0x0204 → order_err=1 and stays set through the sentinel; cleared by the next start.
